// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the fetch front end.
package rv32_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  // RUN issues requests; DRAIN waits for stale responses after a redirect.
  typedef enum logic [0:0] {
    FS_RUN   = 1'b0,
    FS_DRAIN = 1'b1
  } fetch_state_e;

  // One prefetch buffer entry handed to decode.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Instruction addresses are always word aligned.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; read data is combinational from the head and reads 0 when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care while count says empty.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: sequential PC generation, credit-limited imem requests,
// prefetch buffering toward decode and redirect handling with stale-response drain.
module instr_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OW = $clog2(MAX_OUTST) + 1;

  fetch_state_e    state;
  logic [XLEN-1:0] fetch_pc;
  logic [OW-1:0]   outst;
  logic [OW-1:0]   drop;
  logic [OW-1:0]   outst_left;
  logic [31:0]     credit_used;

  logic            req_fire;
  logic            rsp_keep;
  logic            pf_pop;
  fetch_entry_t    pf_in;
  fetch_entry_t    pf_out;
  logic [CW-1:0]   pf_cnt;
  logic            pf_full;
  logic            pf_empty;

  logic [XLEN-1:0] tag_pc;
  logic [OW-1:0]   tag_cnt;
  logic            tag_full;
  logic            tag_empty;
  logic            unused_status;

  // Occupancy flags not needed by the control path.
  assign unused_status = &{1'b0, pf_full, tag_cnt, tag_full, tag_empty};

  // In-flight count once this cycle's response (if any) is retired.
  assign outst_left  = outst - OW'(imem_rsp_valid);
  // Every request in flight owns a prefetch slot, so a response can never overflow.
  assign credit_used = 32'(pf_cnt) + 32'(outst);

  // Gated by rst so no request escapes while reset is held.
  assign imem_req_valid = rst && (state == FS_RUN) && !redirect_valid &&
                          (outst < OW'(MAX_OUTST)) && (credit_used < FIFO_DEPTH);
  assign imem_addr      = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses landing while a drop is pending, or in a redirect cycle, belong to the old stream.
  assign rsp_keep = imem_rsp_valid && !redirect_valid && (drop == '0);

  assign pf_in    = '{pc: tag_pc, instr: imem_rsp_data};
  assign if_valid = !pf_empty;
  assign if_pc    = pf_out.pc;
  assign if_instr = pf_out.instr;
  assign pf_pop   = if_valid && if_ready;

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_prefetch (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_keep),
    .pop   (pf_pop),
    .flush (redirect_valid),
    .wdata (pf_in),
    .rdata (pf_out),
    .count (pf_cnt),
    .full  (pf_full),
    .empty (pf_empty)
  );

  // PC tags for live requests; flushed on redirect since dropped responses never consume a tag.
  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTST)
  ) u_pc_tags (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .pop   (rsp_keep),
    .flush (redirect_valid),
    .wdata (fetch_pc),
    .rdata (tag_pc),
    .count (tag_cnt),
    .full  (tag_full),
    .empty (tag_empty)
  );

  // Fetch PC, in-flight/drop accounting and RUN/DRAIN control.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= FS_RUN;
      fetch_pc <= RESET_PC;
      outst    <= '0;
      drop     <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight is stale; in DRAIN drop already equals outst,
      // so this same assignment only reloads the PC there.
      fetch_pc <= align_pc(redirect_pc);
      outst    <= outst_left;
      drop     <= outst_left;
      state    <= (outst_left != '0) ? FS_DRAIN : FS_RUN;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      outst <= outst_left + OW'(req_fire);
      if (imem_rsp_valid && (drop != '0)) begin
        drop <= drop - OW'(1);
        if (drop == OW'(1)) state <= FS_RUN;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order, fixed-latency memory model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        req_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        redir_v = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        if_ready = 1'b0;

  logic        rst_a, rst_b;
  logic        req_valid_a, req_valid_b, ifv_a, ifv_b;
  logic [31:0] addr_a, addr_b, pc_a, pc_b, instr_a, instr_b;
  logic        m_req_valid, m_ifv;
  logic [31:0] m_addr, m_pc, m_instr;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  int unsigned lat = 1;

  always #5 clk = ~clk;

  // Only the selected instance runs; the other is held in reset.
  assign rst_a = rst & ~sel;
  assign rst_b = rst & sel;
  assign m_req_valid = sel ? req_valid_b : req_valid_a;
  assign m_addr      = sel ? addr_b : addr_a;
  assign m_ifv       = sel ? ifv_b : ifv_a;
  assign m_pc        = sel ? pc_b : pc_a;
  assign m_instr     = sel ? instr_b : instr_a;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4), .MAX_OUTST(2)) u_dut (
    .clk(clk), .rst(rst_a),
    .imem_req_valid(req_valid_a), .imem_req_ready(req_ready), .imem_addr(addr_a),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redir_v), .redirect_pc(redir_pc),
    .if_valid(ifv_a), .if_ready(if_ready), .if_pc(pc_a), .if_instr(instr_a)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4), .MAX_OUTST(2)) u_wrap (
    .clk(clk), .rst(rst_b),
    .imem_req_valid(req_valid_b), .imem_req_ready(req_ready), .imem_addr(addr_b),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redir_v), .redirect_pc(redir_pc),
    .if_valid(ifv_b), .if_ready(if_ready), .if_pc(pc_b), .if_instr(instr_b)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;
  pend_t pend[$];

  // One cycle: drive inputs mid-cycle, then let the memory answer and accept.
  task automatic step(input logic r, input logic s, input logic ir, input logic rr,
                      input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    rst = r; sel = s; if_ready = ir; req_ready = rr; redir_v = rv; redir_pc = rpc;
    #1;
    if (!rst) begin
      pend.delete();
      rsp_valid = 1'b0;
      rsp_data  = '0;
    end else begin
      if (pend.size() > 0 && pend[0].due == cyc) begin
        rsp_valid = 1'b1;
        rsp_data  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        rsp_valid = 1'b0;
        rsp_data  = 32'hDEAD_BEEF;
      end
      if (m_req_valid && req_ready) pend.push_back('{addr: m_addr, due: cyc + lat});
    end
    cyc++;
  endtask

  task automatic expect_out(input string name, input logic ereq, input logic [31:0] eaddr,
                            input logic eifv, input logic [31:0] epc);
    logic [31:0] xpc, xinstr;
    xpc    = eifv ? epc : 32'h0;
    xinstr = eifv ? mem_word(epc) : 32'h0;
    vectors++;
    if (m_req_valid !== ereq) begin
      miscompares++;
      $display("FAIL %s imem_req_valid: got %0b want %0b", name, m_req_valid, ereq);
    end
    if (m_addr !== eaddr) begin
      miscompares++;
      $display("FAIL %s imem_addr: got %h want %h", name, m_addr, eaddr);
    end
    if (m_ifv !== eifv) begin
      miscompares++;
      $display("FAIL %s if_valid: got %0b want %0b", name, m_ifv, eifv);
    end
    if (m_pc !== xpc) begin
      miscompares++;
      $display("FAIL %s if_pc: got %h want %h", name, m_pc, xpc);
    end
    if (m_instr !== xinstr) begin
      miscompares++;
      $display("FAIL %s if_instr: got %h want %h", name, m_instr, xinstr);
    end
  endtask

  typedef struct {
    string       name;
    logic        r, s, ir, rr;
    logic        ereq;
    logic [31:0] eaddr;
    logic        eifv;
    logic [31:0] epc;
    logic        chk;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(input string n, input logic s, input logic ir, input logic rr,
                             input logic ereq, input logic [31:0] ea, input logic eifv,
                             input logic [31:0] epc);
    vec_t t;
    t = '{name: n, r: 1'b1, s: s, ir: ir, rr: rr, ereq: ereq, eaddr: ea,
          eifv: eifv, epc: epc, chk: 1'b1};
    return t;
  endfunction

  // Two settling cycles of reset, then the reset state is checked on the third.
  function automatic void add_reset(input string n, input logic s, input logic [31:0] rpc);
    vec_t t;
    t = v(n, s, 1'b1, 1'b1, 1'b0, rpc, 1'b0, 32'h0);
    t.r = 1'b0;
    t.chk = 1'b0;
    tbl.push_back(t);
    tbl.push_back(t);
    t.chk = 1'b1;
    tbl.push_back(t);
  endfunction

  task automatic do_reset(input string n);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    expect_out(n, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    // 1: streaming, memory ready, 1-cycle latency
    add_reset("rst1", 1'b0, 32'h0);
    tbl.push_back(v("s_c0", 0, 1, 1, 1, 32'h00, 0, 32'h0));
    tbl.push_back(v("s_c1", 0, 1, 1, 1, 32'h04, 0, 32'h0));
    tbl.push_back(v("s_c2", 0, 1, 1, 1, 32'h08, 1, 32'h0));
    tbl.push_back(v("s_c3", 0, 1, 1, 1, 32'h0C, 1, 32'h4));
    tbl.push_back(v("s_c4", 0, 1, 1, 1, 32'h10, 1, 32'h8));
    tbl.push_back(v("s_c5", 0, 1, 1, 1, 32'h14, 1, 32'hC));
    // 2: decode backpressure fills the prefetch buffer, then drains in order
    add_reset("rst2", 1'b0, 32'h0);
    tbl.push_back(v("bp_c0",  0, 0, 1, 1, 32'h00, 0, 32'h0));
    tbl.push_back(v("bp_c1",  0, 0, 1, 1, 32'h04, 0, 32'h0));
    tbl.push_back(v("bp_c2",  0, 0, 1, 1, 32'h08, 1, 32'h0));
    tbl.push_back(v("bp_c3",  0, 0, 1, 1, 32'h0C, 1, 32'h0));
    tbl.push_back(v("bp_c4",  0, 0, 1, 0, 32'h10, 1, 32'h0));
    tbl.push_back(v("bp_c5",  0, 0, 1, 0, 32'h10, 1, 32'h0));
    tbl.push_back(v("bp_c6",  0, 1, 1, 0, 32'h10, 1, 32'h0));
    tbl.push_back(v("bp_c7",  0, 1, 1, 1, 32'h10, 1, 32'h4));
    tbl.push_back(v("bp_c8",  0, 1, 1, 1, 32'h14, 1, 32'h8));
    tbl.push_back(v("bp_c9",  0, 1, 1, 1, 32'h18, 1, 32'hC));
    tbl.push_back(v("bp_c10", 0, 1, 1, 1, 32'h1C, 1, 32'h10));
    // 3: memory stall holds the request address
    add_reset("rst3", 1'b0, 32'h0);
    tbl.push_back(v("st_c0", 0, 1, 1, 1, 32'h00, 0, 32'h0));
    tbl.push_back(v("st_c1", 0, 1, 1, 1, 32'h04, 0, 32'h0));
    tbl.push_back(v("st_c2", 0, 1, 0, 1, 32'h08, 1, 32'h0));
    tbl.push_back(v("st_c3", 0, 1, 0, 1, 32'h08, 1, 32'h4));
    tbl.push_back(v("st_c4", 0, 1, 0, 1, 32'h08, 0, 32'h0));
    tbl.push_back(v("st_c5", 0, 1, 0, 1, 32'h08, 0, 32'h0));
    tbl.push_back(v("st_c6", 0, 1, 0, 1, 32'h08, 0, 32'h0));
    tbl.push_back(v("st_c7", 0, 1, 1, 1, 32'h08, 0, 32'h0));
    tbl.push_back(v("st_c8", 0, 1, 1, 1, 32'h0C, 0, 32'h0));
    tbl.push_back(v("st_c9", 0, 1, 1, 1, 32'h10, 1, 32'h8));
    // 6: address wrap on the second instance
    add_reset("rst6", 1'b1, 32'hFFFF_FFF8);
    tbl.push_back(v("wr_c0", 1, 1, 1, 1, 32'hFFFF_FFF8, 0, 32'h0));
    tbl.push_back(v("wr_c1", 1, 1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0));
    tbl.push_back(v("wr_c2", 1, 1, 1, 1, 32'h0000_0000, 1, 32'hFFFF_FFF8));
    tbl.push_back(v("wr_c3", 1, 1, 1, 1, 32'h0000_0004, 1, 32'hFFFF_FFFC));
    tbl.push_back(v("wr_c4", 1, 1, 1, 1, 32'h0000_0008, 1, 32'h0000_0000));

    lat = 1;
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].s, tbl[i].ir, tbl[i].rr, 1'b0, 32'h0);
      if (tbl[i].chk) expect_out(tbl[i].name, tbl[i].ereq, tbl[i].eaddr, tbl[i].eifv, tbl[i].epc);
    end

    // 4: redirect with two requests in flight (3-cycle memory)
    lat = 3;
    do_reset("rst4");
    step(1, 0, 1, 1, 0, 32'h0);   expect_out("rd_c0", 1, 32'h000, 0, 32'h0);
    step(1, 0, 1, 1, 0, 32'h0);   expect_out("rd_c1", 1, 32'h004, 0, 32'h0);
    step(1, 0, 1, 1, 1, 32'h100); expect_out("rd_c2", 0, 32'h008, 0, 32'h0);
    step(1, 0, 1, 1, 0, 32'h0);   expect_out("rd_c3", 0, 32'h100, 0, 32'h0);
    vectors++;
    if (u_dut.state !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_c3 state: got %0b want 1 (DRAIN)", u_dut.state);
    end
    step(1, 0, 1, 1, 0, 32'h0);   expect_out("rd_c4",  0, 32'h100, 0, 32'h0);
    step(1, 0, 1, 1, 0, 32'h0);   expect_out("rd_c5",  1, 32'h100, 0, 32'h0);
    step(1, 0, 1, 1, 0, 32'h0);   expect_out("rd_c6",  1, 32'h104, 0, 32'h0);
    step(1, 0, 1, 1, 0, 32'h0);   expect_out("rd_c7",  0, 32'h108, 0, 32'h0);
    step(1, 0, 1, 1, 0, 32'h0);   expect_out("rd_c8",  0, 32'h108, 0, 32'h0);
    step(1, 0, 1, 1, 0, 32'h0);   expect_out("rd_c9",  1, 32'h108, 1, 32'h100);
    step(1, 0, 1, 1, 0, 32'h0);   expect_out("rd_c10", 1, 32'h10C, 1, 32'h104);

    // 5: unaligned redirect coincident with a response and a pop
    lat = 1;
    do_reset("rst5");
    step(1, 0, 1, 1, 0, 32'h0);   expect_out("rc_c0", 1, 32'h000, 0, 32'h0);
    step(1, 0, 1, 1, 0, 32'h0);   expect_out("rc_c1", 1, 32'h004, 0, 32'h0);
    step(1, 0, 1, 1, 0, 32'h0);   expect_out("rc_c2", 1, 32'h008, 1, 32'h0);
    step(1, 0, 1, 1, 1, 32'h203); expect_out("rc_c3", 0, 32'h00C, 1, 32'h4);
    step(1, 0, 1, 1, 0, 32'h0);   expect_out("rc_c4", 1, 32'h200, 0, 32'h0);
    step(1, 0, 1, 1, 0, 32'h0);   expect_out("rc_c5", 1, 32'h204, 0, 32'h0);
    step(1, 0, 1, 1, 0, 32'h0);   expect_out("rc_c6", 1, 32'h208, 1, 32'h200);
    step(1, 0, 1, 1, 0, 32'h0);   expect_out("rc_c7", 1, 32'h20C, 1, 32'h204);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
